// File: rtl/dsd7_scratch_mem.sv
// dsd7_scratch_mem: single-port scratchpad RAM with half-word lanes and a load-reserved/store-conditional reservation
module dsd7_scratch_mem #(
    parameter logic [17:0] BASE = 18'h3FFF0,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        wr_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic        sr_i,
    input  logic        cr_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        rb_o
);
    localparam int AW = DEPTH_LOG2;
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, WAIT_NACK} state_t;

    state_t state_q, state_d;
    logic ack_q, ack_d, rb_q, rb_d, resv_valid_q, resv_valid_d;
    logic [31:0] dat_q, dat_d, rd_q;
    logic [AW-1:0] idx_q, idx_d, resv_adr_q, resv_adr_d, adr_w;
    logic [1:0] we;
    logic cs, hit, unused_bits;
    logic [31:0] mem [0:(1<<AW)-1];

    assign adr_w = adr_i[AW+1:2];
    assign cs = cyc_i & stb_i & (adr_i[31:14] == BASE);
    assign hit = resv_valid_q & (resv_adr_q == adr_w);
    assign unused_bits = ^adr_i[1:0];

    always_comb begin
        state_d = state_q;
        ack_d = ack_q;
        dat_d = dat_q;
        rb_d = rb_q;
        resv_valid_d = resv_valid_q;
        resv_adr_d = resv_adr_q;
        idx_d = idx_q;
        we = 2'b00;
        case (state_q)
            IDLE: if (cs) begin
                state_d = wr_i ? WR : RD1;
                idx_d = adr_w;
                if (!wr_i && sr_i) begin
                    resv_valid_d = 1'b1;
                    resv_adr_d = adr_w;
                end
            end
            RD1: state_d = RD2;
            RD2: begin
                ack_d = 1'b1;
                dat_d = rd_q;
                rb_d = resv_valid_q;
                state_d = WAIT_NACK;
            end
            WR: begin
                // a failed store-conditional still acks but leaves the RAM untouched
                ack_d = 1'b1;
                dat_d = '0;
                rb_d = cr_i & hit;
                we = (cr_i && !hit) ? 2'b00 : sel_i;
                resv_valid_d = (cr_i || hit) ? 1'b0 : resv_valid_q;
                state_d = WAIT_NACK;
            end
            WAIT_NACK: if (!stb_i) begin
                ack_d = 1'b0;
                dat_d = '0;
                rb_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !cyc_i) begin
            state_d = IDLE;
            ack_d = 1'b0;
            dat_d = '0;
            rb_d = 1'b0;
            we = 2'b00;
            resv_valid_d = resv_valid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ack_q <= 1'b0;
            dat_q <= '0;
            rb_q <= 1'b0;
            resv_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
            rb_q <= rb_d;
            resv_valid_q <= resv_valid_d;
            resv_adr_q <= resv_adr_d;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        rd_q <= mem[idx_q];
        if (rst_i && we[0]) mem[adr_w][15:0] <= dat_i[15:0];
        if (rst_i && we[1]) mem[adr_w][31:16] <= dat_i[31:16];
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign rb_o = rb_q;
endmodule

// File: tb/tb_dsd7_scratch_mem.sv
// tb_dsd7_scratch_mem: directed transactions checked every cycle against a transaction-level memory/reservation model
module tb_dsd7_scratch_mem;
    localparam logic [17:0] BASE = 18'h3FFF0;

    logic clk = 1'b0;
    logic rst_n, cyc, stb, wr, sr, cr;
    logic [1:0] sel;
    logic [31:0] adr, din;
    logic ack_o, rb_o;
    logic [31:0] dat_o;

    logic exp_ack, exp_rb;
    logic [31:0] exp_dat;
    logic [31:0] mem_m [0:4095];
    logic rv;
    logic [11:0] ra;
    int total = 0;
    int bad = 0;

    logic [31:0] d;
    logic b;

    always #5 clk = ~clk;

    dsd7_scratch_mem dut (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .wr_i(wr),
        .sel_i(sel), .adr_i(adr), .dat_i(din), .sr_i(sr), .cr_i(cr),
        .ack_o(ack_o), .dat_o(dat_o), .rb_o(rb_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic set_exp(input logic a, input logic [31:0] dd, input logic r);
        exp_ack = a;
        exp_dat = dd;
        exp_rb = r;
    endtask

    // one clock edge, then compare every output against the expectation for that cycle
    task automatic step();
        @(posedge clk);
        #2;
        chk("ack_o", {31'b0, ack_o}, {31'b0, exp_ack});
        chk("dat_o", dat_o, exp_dat);
        chk("rb_o", {31'b0, rb_o}, {31'b0, exp_rb});
        @(negedge clk);
    endtask

    task automatic drive(input logic [13:0] off, input logic w, input logic [31:0] dd,
                         input logic [1:0] s, input logic r, input logic c);
        cyc = 1'b1; stb = 1'b1; wr = w; adr = {BASE, off}; din = dd; sel = s; sr = r; cr = c;
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; wr = 1'b0; sr = 1'b0; cr = 1'b0;
        set_exp(1'b0, 32'h0, 1'b0);
        step();
    endtask

    task automatic do_read(input logic [13:0] off, input logic r, input int hold,
                           output logic [31:0] rd, output logic rrb);
        drive(off, 1'b0, 32'h0, 2'b11, r, 1'b0);
        if (r) begin rv = 1'b1; ra = off[13:2]; end
        set_exp(1'b0, 32'h0, 1'b0);
        step();
        sr = 1'b0;
        step();
        set_exp(1'b1, mem_m[off[13:2]], rv);
        step();
        rd = dat_o;
        rrb = rb_o;
        repeat (hold) step();
        release_bus();
    endtask

    task automatic do_write(input logic [13:0] off, input logic [31:0] dd, input logic [1:0] s,
                            input logic c, input int hold, output logic rrb);
        logic ok;
        drive(off, 1'b1, dd, s, 1'b0, c);
        set_exp(1'b0, 32'h0, 1'b0);
        step();
        ok = rv && (ra == off[13:2]);
        if (!c || ok) begin
            if (s[0]) mem_m[off[13:2]][15:0] = dd[15:0];
            if (s[1]) mem_m[off[13:2]][31:16] = dd[31:16];
        end
        if (c || ok) rv = 1'b0;
        set_exp(1'b1, 32'h0, c & ok);
        step();
        rrb = rb_o;
        repeat (hold) step();
        release_bus();
    endtask

    initial begin
        rv = 1'b0; ra = '0;
        for (int i = 0; i < 4096; i++) mem_m[i] = '0;
        rst_n = 1'b0; cyc = 0; stb = 0; wr = 0; sr = 0; cr = 0; sel = 0; adr = 0; din = 0;
        set_exp(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        do_write(14'h010, 32'h12345678, 2'b11, 1'b0, 0, b);
        chk("w1_rb", {31'b0, b}, 32'h0);
        do_read(14'h010, 1'b0, 0, d, b);
        chk("r1_dat", d, 32'h12345678);
        chk("r1_rb", {31'b0, b}, 32'h0);

        do_write(14'h010, 32'hAAAA0000, 2'b10, 1'b0, 2, b);
        do_read(14'h013, 1'b0, 3, d, b);
        chk("r2_dat", d, 32'hAAAA5678);

        do_read(14'h010, 1'b1, 0, d, b);
        chk("lr_rb", {31'b0, b}, 32'h1);
        do_write(14'h010, 32'h00000001, 2'b11, 1'b1, 0, b);
        chk("sc_ok_rb", {31'b0, b}, 32'h1);
        do_read(14'h010, 1'b0, 0, d, b);
        chk("sc_ok_dat", d, 32'h00000001);
        chk("sc_ok_clear", {31'b0, b}, 32'h0);
        do_write(14'h010, 32'h00000009, 2'b11, 1'b1, 0, b);
        chk("sc_again_rb", {31'b0, b}, 32'h0);

        do_read(14'h010, 1'b1, 0, d, b);
        do_write(14'h010, 32'hCAFEF00D, 2'b11, 1'b0, 0, b);
        do_write(14'h010, 32'h00000002, 2'b11, 1'b1, 0, b);
        chk("sc_lost_rb", {31'b0, b}, 32'h0);
        do_read(14'h010, 1'b0, 0, d, b);
        chk("sc_lost_dat", d, 32'hCAFEF00D);

        do_read(14'h010, 1'b1, 0, d, b);
        do_read(14'h020, 1'b1, 0, d, b);
        do_write(14'h010, 32'h0BAD0BAD, 2'b11, 1'b1, 0, b);
        chk("resv_moved_rb", {31'b0, b}, 32'h0);

        do_read(14'h010, 1'b1, 0, d, b);
        do_write(14'h010, 32'hFFFFFFFF, 2'b00, 1'b0, 0, b);
        do_write(14'h010, 32'h00000003, 2'b11, 1'b1, 0, b);
        chk("sel0_clear_rb", {31'b0, b}, 32'h0);
        do_read(14'h010, 1'b0, 0, d, b);
        chk("sel0_dat", d, 32'hCAFEF00D);

        do_write(14'h0000, 32'h11112222, 2'b01, 1'b0, 0, b);
        do_write(14'h3FFC, 32'h33334444, 2'b11, 1'b0, 0, b);
        do_read(14'h3FFC, 1'b0, 0, d, b);
        chk("top_dat", d, 32'h33334444);
        do_read(14'h0000, 1'b0, 0, d, b);
        chk("bot_dat", d, 32'h00002222);

        drive(14'h010, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0);
        adr = {18'h3FFF1, 14'h010};
        set_exp(1'b0, 32'h0, 1'b0);
        repeat (10) step();
        release_bus();

        drive(14'h010, 1'b1, 32'h55555555, 2'b11, 1'b0, 1'b0);
        step();
        cyc = 1'b0; stb = 1'b0;
        step();
        release_bus();

        drive(14'h010, 1'b1, 32'h66666666, 2'b11, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        release_bus();

        do_read(14'h020, 1'b1, 0, d, b);
        drive(14'h010, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        rv = 1'b0;
        step();
        rst_n = 1'b1;
        release_bus();
        do_read(14'h010, 1'b0, 0, d, b);
        chk("post_rst_dat", d, 32'hCAFEF00D);
        chk("post_rst_rb", {31'b0, b}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsd7_scratch_mem.md
DSD7_SCRATCH_MEM -- requirements
Module: dsd7_scratch_mem

Interface
- REQ-001 SHALL have parameter BASE, default 18'h3FFF0, the match value for adr_i[31:14].
- REQ-002 SHALL have parameter DEPTH_LOG2, default 12: 4096 words of 32 bits.
- REQ-003 SHALL have port clk_i, input, 1: the single clock.
- REQ-004 SHALL have port rst_i, input, 1: synchronous reset, active-low.
- REQ-005 SHALL have port cyc_i, input, 1: bus cycle valid.
- REQ-006 SHALL have port stb_i, input, 1: strobe.
- REQ-007 SHALL have port wr_i, input, 1: write when 1, read when 0.
- REQ-008 SHALL have port sel_i, input, 2: half-word lane selects; bit0 = dat[15:0], bit1 = dat[31:16].
- REQ-009 SHALL have port adr_i, input, 32: byte address; word index = adr_i[13:2].
- REQ-010 SHALL have port dat_i, input, 32: write data.
- REQ-011 SHALL have port sr_i, input, 1: set reservation (load-reserved).
- REQ-012 SHALL have port cr_i, input, 1: conditional write (store-conditional).
- REQ-013 SHALL have port ack_o, output, 1: transfer acknowledge.
- REQ-014 SHALL have port dat_o, output, 32: read data; 0 when not acknowledging a read.
- REQ-015 SHALL have port rb_o, output, 1: reservation status returned with ack.

Function
- REQ-016 cs SHALL equal cyc_i & stb_i & (adr_i[31:14]==BASE); no response when cs=0.
- REQ-017 SHALL implement FSM states IDLE, RD1, RD2, WR, WAIT_NACK.
- REQ-018 In IDLE, on cs & ~wr_i: register the word index, go to RD1; if sr_i, set resv_valid=1 and resv_adr=adr_i[13:2] in the same cycle.
- REQ-019 RD1 SHALL go to RD2 (synchronous RAM read cycle).
- REQ-020 RD2 SHALL assert ack_o=1, drive dat_o=RAM word, set rb_o=resv_valid, and go to WAIT_NACK; read ack therefore occurs in the 3rd cycle after cs is sampled.
- REQ-021 In IDLE, on cs & wr_i: go to WR.
- REQ-022 In WR, with cr_i=0: write the lanes selected by sel_i, assert ack_o, set rb_o=0, go to WAIT_NACK.
- REQ-023 In WR, with cr_i=1: write only if resv_valid & (resv_adr==adr_i[13:2]); set rb_o to that condition; clear resv_valid in either case; assert ack_o.
- REQ-024 An ordinary write (cr_i=0) whose word index equals resv_adr while resv_valid=1 SHALL clear resv_valid.
- REQ-025 sel_i=2'b00 on a write SHALL modify no RAM bits but SHALL still be acknowledged and apply the REQ-024/023 reservation rules.
- REQ-026 WAIT_NACK SHALL hold ack_o, dat_o, and rb_o until stb_i=0; it SHALL then drive ack_o=0, dat_o=0, rb_o=0 and go to IDLE.
- REQ-027 cyc_i=0 in any non-IDLE state SHALL abort to IDLE with ack_o=0 and dat_o=0; a write aborted before WR performs no RAM update.
- REQ-028 A new cs SHALL NOT be accepted until IDLE is re-entered; minimum 1 idle cycle between transfers.
- REQ-029 Reservation SHALL be single-entry; a new sr_i read SHALL overwrite resv_adr.
- REQ-030 Address wrap SHALL be none: adr_i[1:0] ignored; adr_i[13:2] covers the full depth.

Reset
- REQ-031 While rst_i=0 at a clock edge: state=IDLE, ack_o=0, dat_o=0, rb_o=0, resv_valid=0.
- REQ-032 Reset SHALL take effect mid-transaction with no RAM write issued in that cycle; RAM contents SHALL NOT be reset.

Verification
- REQ-033 Write 32'h12345678, sel=11, to BASE:0x010; then read the same address -> read ack 3 cycles after cs, dat_o=32'h12345678, rb_o=0.
- REQ-034 Write 32'hAAAA0000, sel=10, to the same address; then read -> dat_o=32'hAAAA5678.
- REQ-035 Read 0x010 with sr_i=1 (rb_o=1); then write 32'h1 with cr_i=1 -> rb_o=1, read-back=32'h1, resv_valid=0.
- REQ-036 sr_i read of 0x010; ordinary write to 0x010; then cr_i write of 32'h2 -> rb_o=0, memory still holds the ordinary write data.
- REQ-037 adr_i[31:14]!=BASE with cyc_i=stb_i=1 for 10 cycles -> ack_o stays 0; rst_i=0 during RD1 -> next cycle ack_o=0, state IDLE.
